hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Tracks the destination register and the cycles until its result is ready
//   for the instructions in the E, M and W pipeline stages.
//   From these slots and the instruction in decode it produces:
//     - a stall request, which holds the PC and decode and puts a bubble into E
//     - per-operand forwarding selects
//     - a saturating count of stall cycles
//
// Configuration:
//   HAZARD_FWD_EN  When defined, each operand takes its value from the
//                  youngest matching slot once that slot's tnew reaches 0.
//                  Decode stalls only while that slot's tnew is greater than
//                  the operand's use distance.
//                  When undefined, any match in E or M stalls, a match in W
//                  never stalls because the register file writes through,
//                  and both forwarding selects are tied to 0.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   d_valid    in   1   decode slot holds a real instruction (0 = bubble)
//   d_rs       in   5   decode source register rs
//   d_rt       in   5   decode source register rt
//   d_rsuse    in   4   cycles until rs is needed; 4'hf = not used
//   d_rtuse    in   4   cycles until rt is needed; 4'hf = not used
//   d_tarreg   in   5   destination register; 0 = no write
//   d_tnew     in   4   cycles from decode until the result exists
//   stall      out  1   hold PC and decode, insert a bubble into E
//   fwd_rs     out  2   rs source: 0 = regfile, 1 = E, 2 = M, 3 = W
//   fwd_rt     out  2   rt source: same encoding as fwd_rs
//   stall_cnt  out  16  stall cycles seen, saturates at 16'hffff
// -----------------------------------------------------------------------------
module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [3:0]  d_rsuse,
  input  logic [3:0]  d_rtuse,
  input  logic [4:0]  d_tarreg,
  input  logic [3:0]  d_tnew,
  output logic        stall,
  output logic [1:0]  fwd_rs,
  output logic [1:0]  fwd_rt,
  output logic [15:0] stall_cnt
);

  localparam int NSLOT = 3;  // index 0 = E, 1 = M, 2 = W
  localparam int NOP   = 2;  // index 0 = rs, 1 = rt

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  logic        slot_valid_q [NSLOT];
  logic [4:0]  slot_tar_q   [NSLOT];
  logic [3:0]  slot_tnew_q  [NSLOT];
  logic        slot_valid_d [NSLOT];
  logic [4:0]  slot_tar_d   [NSLOT];
  logic [3:0]  slot_tnew_d  [NSLOT];
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic [4:0]  op_reg [NOP];
  logic [3:0]  op_use [NOP];
  logic [2:0]  op_hit [NOP];
  logic [1:0]  op_stall;
  logic [1:0]  op_fwd [NOP];

  assign op_reg[0] = d_rs;
  assign op_reg[1] = d_rt;
  assign op_use[0] = d_rsuse;
  assign op_use[1] = d_rtuse;

  // Slot advance: E takes decode unless stalled or bubbled.
  // M and W shift down.
  // Every move ages tnew by one, with a floor of 0.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi == 0) begin : g_e
        logic load_e;
        assign load_e          = d_valid & ~stall;
        assign slot_valid_d[0] = load_e;
        assign slot_tar_d[0]   = load_e ? d_tarreg : 5'd0;
        assign slot_tnew_d[0]  = load_e ? sat_dec(d_tnew) : 4'd0;
      end else begin : g_mw
        assign slot_valid_d[gi] = slot_valid_q[gi-1];
        assign slot_tar_d[gi]   = slot_tar_q[gi-1];
        assign slot_tnew_d[gi]  = sat_dec(slot_tnew_q[gi-1]);
      end
    end

    // A slot matches an operand only for a real decode instruction.
    // The operand register must be nonzero and actually used.
    // The slot must be valid and write that same register.
    for (gi = 0; gi < NOP; gi++) begin : g_op
      for (gj = 0; gj < NSLOT; gj++) begin : g_cmp
        assign op_hit[gi][gj] = d_valid && slot_valid_q[gj] &&
                                (slot_tar_q[gj] == op_reg[gi]) &&
                                (op_reg[gi] != 5'd0) &&
                                (op_use[gi] != 4'hf);
      end
    end
  endgenerate

  // Walk the slots from oldest (W) to youngest (E).
  // A later hit overwrites an earlier one, so the youngest match decides.
  always_comb begin
    op_stall  = 2'b00;
    op_fwd[0] = 2'd0;
    op_fwd[1] = 2'd0;
    for (int op = 0; op < NOP; op++) begin
      for (int s = NSLOT - 1; s >= 0; s--) begin
        if (op_hit[op][s]) begin
`ifdef HAZARD_FWD_EN
          op_stall[op] = (slot_tnew_q[s] > op_use[op]);
          op_fwd[op]   = (slot_tnew_q[s] == 4'd0) ? 2'(s + 1) : 2'd0;
`else
          // Without a forwarding network, only the regfile write-through
          // from W is usable.
          op_stall[op] = (s != NSLOT - 1);
`endif
        end
      end
    end
  end

  assign stall  = |op_stall;
  assign fwd_rs = op_fwd[0];
  assign fwd_rt = op_fwd[1];

  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hffff)) ? stall_cnt_q + 16'd1
                                                            : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSLOT; s++) begin
        slot_valid_q[s] <= 1'b0;
        slot_tar_q[s]   <= 5'd0;
        slot_tnew_q[s]  <= 4'd0;
      end
      stall_cnt_q <= 16'd0;
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        slot_valid_q[s] <= slot_valid_d[s];
        slot_tar_q[s]   <= slot_tar_d[s];
        slot_tnew_q[s]  <= slot_tnew_d[s];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
